// File: rtl/pong_pkg.sv
// Shared types and widths for the pong game-logic slice.
package pong_pkg;

    localparam int POS_W   = 10;
    localparam int SCORE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        SCORED,
        GAME_OVER
    } ball_state_t;

    typedef enum logic {
        DIR_NEG,
        DIR_POS
    } dir_t;

    // Score increment that sticks at the top of the counter range.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        logic [SCORE_W-1:0] r;
        if (s == {SCORE_W{1'b1}}) begin
            r = s;
        end else begin
            r = s + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ball_controller_tick_gen.sv
// Rising-edge detector: turns the slow game clock into one-clk ticks.
// History resets high so a level that is already high at reset release
// never produces a tick.
module tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    output logic tick_o
);

    logic prev_q;

    // Remember last cycle's level; reset to 1 to suppress a spurious edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level_i;
        end
    end

    assign tick_o = level_i & ~prev_q;

endmodule

// File: rtl/ball_controller.sv
// Pong ball controller: moves the ball one step per game tick, resolves
// wall bounces, paddle hits and misses, keeps score and sequences
// serve / point / game-over.
// Optional feature macro: BALL_SPEEDUP_EN (step grows by one per paddle
// hit, capped at twice the base step, reloaded on serve).
module ball_controller
    import pong_pkg::*;
#(
    parameter int SCREEN_W         = 640,
    parameter int SCREEN_H         = 480,
    parameter int BALL_SIZE        = 8,
    parameter int PADDLE_H         = 48,
    parameter int PADDLE_W         = 8,
    parameter int LEFT_PADDLE_COL  = 8,
    parameter int RIGHT_PADDLE_COL = 616,
    parameter int STEP             = 4,
    parameter int WIN_SCORE        = 7,
    parameter int HOLD_TICKS       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               game_clock,
    input  logic               serve,
    input  logic [POS_W-1:0]   left_paddle_top,
    input  logic [POS_W-1:0]   right_paddle_top,
    output logic [POS_W-1:0]   ball_row,
    output logic [POS_W-1:0]   ball_col,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               point_scored,
    output logic               game_over
);

    // One extra bit so sums never wrap before they are compared.
    localparam int W1     = POS_W + 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    localparam logic [W1-1:0]      ROW_MAX   = W1'(SCREEN_H - BALL_SIZE);
    localparam logic [W1-1:0]      COL_MAX   = W1'(SCREEN_W - BALL_SIZE);
    localparam logic [W1-1:0]      RFACE     = W1'(RIGHT_PADDLE_COL - BALL_SIZE);
    localparam logic [W1-1:0]      LFACE     = W1'(LEFT_PADDLE_COL + PADDLE_W);
    localparam logic [W1-1:0]      PAD_H     = W1'(PADDLE_H);
    localparam logic [W1-1:0]      BALL_X    = W1'(BALL_SIZE);
    localparam logic [POS_W-1:0]   ROW_CTR   = POS_W'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [POS_W-1:0]   COL_CTR   = POS_W'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [POS_W-1:0]   STEP_INIT = POS_W'(STEP);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
`ifdef BALL_SPEEDUP_EN
    localparam logic [POS_W-1:0]   STEP_MAX  = POS_W'(2 * STEP);
`endif

    ball_state_t        state_q, state_d;
    logic [POS_W-1:0]   row_q, row_d;
    logic [POS_W-1:0]   col_q, col_d;
    dir_t               dx_q, dx_d;
    dir_t               dy_q, dy_d;
    logic [POS_W-1:0]   step_q, step_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [SCORE_W-1:0] scoreL_q, scoreL_d;
    logic [SCORE_W-1:0] scoreR_q, scoreR_d;
    logic               point_q, point_d;

    logic               tick;
    logic [W1-1:0]      rowX, colX, stepX;
    logic [W1-1:0]      rowPlus, colPlus, lfacePlus;
    logic [W1-1:0]      leftTopX, rightTopX;
    logic               overlapL, overlapR;
    logic               hit, missRight, missLeft;

    tick_gen u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .level_i (game_clock),
        .tick_o  (tick)
    );

    assign rowX      = {1'b0, row_q};
    assign colX      = {1'b0, col_q};
    assign stepX     = {1'b0, step_q};
    assign rowPlus   = rowX + stepX;
    assign colPlus   = colX + stepX;
    assign lfacePlus = LFACE + stepX;
    assign leftTopX  = {1'b0, left_paddle_top};
    assign rightTopX = {1'b0, right_paddle_top};

    // Overlap uses the pre-update row against each paddle's vertical span.
    assign overlapL = (rowX < leftTopX + PAD_H)  && (rowX + BALL_X > leftTopX);
    assign overlapR = (rowX < rightTopX + PAD_H) && (rowX + BALL_X > rightTopX);

    // State and datapath registers; reset parks the ball at centre in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            row_q    <= ROW_CTR;
            col_q    <= COL_CTR;
            dx_q     <= DIR_POS;
            dy_q     <= DIR_POS;
            step_q   <= STEP_INIT;
            hold_q   <= '0;
            scoreL_q <= '0;
            scoreR_q <= '0;
            point_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            step_q   <= step_d;
            hold_q   <= hold_d;
            scoreL_q <= scoreL_d;
            scoreR_q <= scoreR_d;
            point_q  <= point_d;
        end
    end

    // Next-state logic: movement and collision resolution on each tick.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        step_d    = step_q;
        hold_d    = hold_q;
        scoreL_d  = scoreL_q;
        scoreR_d  = scoreR_q;
        point_d   = 1'b0;
        hit       = 1'b0;
        missRight = 1'b0;
        missLeft  = 1'b0;

        case (state_q)
            IDLE: begin
                row_d = ROW_CTR;
                col_d = COL_CTR;
                if (serve) begin
                    state_d = PLAY;
                    dy_d    = DIR_POS;
                    step_d  = STEP_INIT;
                end
            end

            PLAY: begin
                if (tick) begin
                    if (dx_q == DIR_POS) begin
                        if ((colX < RFACE) && (colPlus >= RFACE) && overlapR) begin
                            col_d = RFACE[POS_W-1:0];
                            dx_d  = DIR_NEG;
                            hit   = 1'b1;
                        end else if (colPlus >= COL_MAX) begin
                            missRight = 1'b1;
                        end else begin
                            col_d = col_q + step_q;
                        end
                    end else begin
                        if ((colX > LFACE) && (colX <= lfacePlus) && overlapL) begin
                            col_d = LFACE[POS_W-1:0];
                            dx_d  = DIR_POS;
                            hit   = 1'b1;
                        end else if (colX <= stepX) begin
                            missLeft = 1'b1;
                        end else begin
                            col_d = col_q - step_q;
                        end
                    end

                    if (dy_q == DIR_POS) begin
                        if (rowPlus >= ROW_MAX) begin
                            row_d = ROW_MAX[POS_W-1:0];
                            dy_d  = DIR_NEG;
                        end else begin
                            row_d = row_q + step_q;
                        end
                    end else begin
                        if (rowX <= stepX) begin
                            row_d = '0;
                            dy_d  = DIR_POS;
                        end else begin
                            row_d = row_q - step_q;
                        end
                    end

`ifdef BALL_SPEEDUP_EN
                    if (hit && (step_q < STEP_MAX)) begin
                        step_d = step_q + 1'b1;
                    end
`endif

                    // A miss freezes the ball where it was before this tick.
                    if (missRight || missLeft) begin
                        row_d   = row_q;
                        col_d   = col_q;
                        dy_d    = dy_q;
                        state_d = SCORED;
                        point_d = 1'b1;
                        hold_d  = '0;
                        if (missRight) begin
                            scoreL_d = sat_inc(scoreL_q);
                            dx_d     = DIR_POS;
                        end else begin
                            scoreR_d = sat_inc(scoreR_q);
                            dx_d     = DIR_NEG;
                        end
                    end
                end
            end

            SCORED: begin
                if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d = '0;
                        row_d  = ROW_CTR;
                        col_d  = COL_CTR;
                        if ((scoreL_q == WIN) || (scoreR_q == WIN)) begin
                            state_d = GAME_OVER;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end

            GAME_OVER: begin
                row_d = ROW_CTR;
                col_d = COL_CTR;
                if (serve) begin
                    scoreL_d = '0;
                    scoreR_d = '0;
                    dx_d     = DIR_POS;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ball_row     = row_q;
    assign ball_col     = col_q;
    assign score_left   = scoreL_q;
    assign score_right  = scoreR_q;
    assign point_scored = point_q;
    assign game_over    = (state_q == GAME_OVER);

endmodule
